// File: rtl/spi_controller.sv
// SPI mode-0 write controller: one 16-bit frame {rw, addr[6:0], data[7:0]} per accepted request.
// Optional readback of cipo during the data byte is enabled with `define SPI_CONTROLLER_READBACK_EN.
module spi_controller #(
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int FRAME_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
`ifdef SPI_CONTROLLER_READBACK_EN
  input  logic       cipo,
  output logic [7:0] rsp_data,
`endif
  output logic       copi
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(FRAME_GAP - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [3:0]  bit_idx;
  logic [15:0] shreg;
  logic        done_next;

  // done is registered, so it is armed one cycle ahead of the last GAP cycle
  always_comb begin
    done_next = 1'b0;
    if (state == HOLD && cnt == HOLD_LAST && GAP_LAST == 8'd0)
      done_next = 1'b1;
    else if (state == GAP && cnt != GAP_LAST && (cnt + 8'd1) == GAP_LAST)
      done_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      bit_idx   <= 4'd0;
      shreg     <= 16'd0;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            shreg     <= {req_write, req_addr, req_data};
            state     <= SETUP;
            cnt       <= 8'd0;
            ncs       <= 1'b0;
            sclk      <= 1'b0;
            copi      <= req_write;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= SHIFT;
            cnt     <= 8'd0;
            bit_idx <= 4'd15;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= 8'd0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // copi only moves together with the falling sclk edge
              sclk <= 1'b0;
              if (bit_idx == 4'd0) begin
                state <= HOLD;
                copi  <= 1'b0;
              end else begin
                bit_idx <= bit_idx - 4'd1;
                copi    <= shreg[bit_idx - 4'd1];
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= GAP;
            cnt   <= 8'd0;
            ncs   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_CONTROLLER_READBACK_EN
  logic [7:0] rx;

  // cipo is captured in the first sclk-high cycle of each data bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx       <= 8'd0;
      rsp_data <= 8'd0;
    end else begin
      if (state == IDLE && req_valid)
        rx <= 8'd0;
      else if (state == SHIFT && sclk && cnt == 8'd0 && !bit_idx[3])
        rx <= {rx[6:0], cipo};
      if (done_next)
        rsp_data <= rx;
    end
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: default instance plus a fast-timing instance.
// Exercises the readback path too when SPI_CONTROLLER_READBACK_EN is defined.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       reqValid, reqReady, reqWrite;
  logic [6:0] reqAddr;
  logic [7:0] reqData;
  logic       busy, done, sclk, ncs, copi;

  logic       fValid, fReady, fWrite;
  logic [6:0] fAddr;
  logic [7:0] fData;
  logic       fBusy, fDone, fSclk, fNcs, fCopi;

`ifdef SPI_CONTROLLER_READBACK_EN
  logic       cipo = 1'b0;
  logic [7:0] rspData;
  logic       fCipo = 1'b0;
  logic [7:0] fRspData;
  logic [15:0] cipoWord = 16'h003C;
  int          cipoIdx = 15;
`endif

  spi_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
    .req_addr(reqAddr), .req_data(reqData),
    .busy(busy), .done(done), .sclk(sclk), .ncs(ncs),
`ifdef SPI_CONTROLLER_READBACK_EN
    .cipo(cipo), .rsp_data(rspData),
`endif
    .copi(copi)
  );

  spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .FRAME_GAP(1)) dutFast (
    .clk(clk), .rst(rst),
    .req_valid(fValid), .req_ready(fReady), .req_write(fWrite),
    .req_addr(fAddr), .req_data(fData),
    .busy(fBusy), .done(fDone), .sclk(fSclk), .ncs(fNcs),
`ifdef SPI_CONTROLLER_READBACK_EN
    .cipo(fCipo), .rsp_data(fRspData),
`endif
    .copi(fCopi)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Bus monitor: accumulates running totals that the stimulus compares as deltas
  int          rises = 0, ncsLow = 0, copiViol = 0, doneCnt = 0, rdyViol = 0;
  int          hsN = 0, gapN = 0, highRun = 0;
  int          hsCyc[8];
  int          gapRuns[8];
  logic [31:0] shiftCap = 32'd0;
  logic        prevSclk = 1'b0, prevCopi = 1'b0, prevNcs = 1'b1;
  int          fRises = 0, fViol = 0;
  logic [31:0] fShift = 32'd0;
  logic        fPrevSclk = 1'b0, fPrevCopi = 1'b0;

  always @(negedge clk) begin
    if (!prevSclk && sclk) begin
      rises = rises + 1;
      shiftCap = {shiftCap[30:0], copi};
      if (copi !== prevCopi) copiViol = copiViol + 1;
    end
    if (prevSclk && sclk && copi !== prevCopi) copiViol = copiViol + 1;
    if (!ncs) ncsLow = ncsLow + 1;
    if (ncs) begin
      highRun = highRun + 1;
    end else if (prevNcs) begin
      if (gapN < 8) gapRuns[gapN] = highRun;
      gapN = gapN + 1;
      highRun = 0;
    end
    if (done) doneCnt = doneCnt + 1;
    if (busy && reqReady) rdyViol = rdyViol + 1;
    if (reqValid && reqReady) begin
      if (hsN < 8) hsCyc[hsN] = cyc;
      hsN = hsN + 1;
    end
`ifdef SPI_CONTROLLER_READBACK_EN
    // Peripheral model: presents cipoWord MSB first, advancing on each sclk fall
    if (prevNcs && !ncs) begin
      cipoIdx = 15;
      cipo = cipoWord[cipoIdx];
    end else if (!ncs && prevSclk && !sclk && cipoIdx > 0) begin
      cipoIdx = cipoIdx - 1;
      cipo = cipoWord[cipoIdx];
    end
`endif
    prevSclk = sclk;
    prevCopi = copi;
    prevNcs = ncs;

    if (!fPrevSclk && fSclk) begin
      fRises = fRises + 1;
      fShift = {fShift[30:0], fCopi};
      if (fCopi !== fPrevCopi) fViol = fViol + 1;
    end
    if (fPrevSclk && fSclk && fCopi !== fPrevCopi) fViol = fViol + 1;
    fPrevSclk = fSclk;
    fPrevCopi = fCopi;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request, waits (bounded) for the handshake cycle, then withdraws it
  task automatic applyStimulus(input bit fast, input logic w, input logic [6:0] a,
                               input logic [7:0] d, output int hsAt);
    bit seen;
    @(posedge clk); #1;
    if (fast) begin
      fWrite = w; fAddr = a; fData = d; fValid = 1'b1;
    end else begin
      reqWrite = w; reqAddr = a; reqData = d; reqValid = 1'b1;
    end
    seen = 1'b0;
    hsAt = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (fast ? fReady : reqReady) begin
        seen = 1'b1;
        hsAt = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    fValid = 1'b0;
    reqValid = 1'b0;
    checkOutput("handshake seen", 32'(seen), 32'd1);
  endtask

  task automatic waitDone(input bit fast, input int budget, output int doneAt,
                          output logic [7:0] rsp);
    doneAt = -1;
    rsp = 8'd0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (fast ? fDone : done) begin
        doneAt = cyc;
`ifdef SPI_CONTROLLER_READBACK_EN
        rsp = fast ? fRspData : rspData;
`endif
        break;
      end
    end
    checkOutput("done seen", 32'(doneAt >= 0), 32'd1);
  endtask

  int          hs, dn, r0, n0, v0, d0, h0, g0, k;
  logic        pl;
  logic [7:0]  rsp;

  initial begin
    rst = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 7'd0; reqData = 8'd0;
    fValid = 1'b0; fWrite = 1'b0; fAddr = 7'd0; fData = 8'd0;
    $display("[TB] start");

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst sclk", 32'(sclk), 32'd0);
    checkOutput("rst ncs", 32'(ncs), 32'd1);
    checkOutput("rst copi", 32'(copi), 32'd0);
    checkOutput("rst req_ready", 32'(reqReady), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst fast ncs", 32'(fNcs), 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single write frame addr 0x00 data 0xA5
    r0 = rises; n0 = ncsLow; v0 = copiViol; d0 = doneCnt;
    applyStimulus(1'b0, 1'b1, 7'h00, 8'hA5, hs);
    waitDone(1'b0, 400, dn, rsp);
    checkOutput("frame latency", 32'(dn - hs), 32'd136);
    @(negedge clk);
    checkOutput("done width", 32'(done), 32'd0);
    checkOutput("ready after done", 32'(reqReady), 32'd1);
    checkOutput("busy after done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("rising edges", 32'(rises - r0), 32'd16);
    checkOutput("frame bits", {16'd0, shiftCap[15:0]}, 32'h80A5);
    checkOutput("ncs low cycles", 32'(ncsLow - n0), 32'd132);
    checkOutput("copi stable", 32'(copiViol - v0), 32'd0);
    checkOutput("done pulses", 32'(doneCnt - d0), 32'd1);
`ifdef SPI_CONTROLLER_READBACK_EN
    checkOutput("readback data", {24'd0, rsp}, 32'h3C);
`endif

    // Three back-to-back requests with req_valid held high
    h0 = hsN; g0 = gapN; r0 = rises;
    @(posedge clk); #1;
    reqWrite = 1'b0; reqAddr = 7'h7F; reqData = 8'h3C; reqValid = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if (hsN >= h0 + 3) break;
    end
    reqValid = 1'b0;
    checkOutput("b2b handshakes", 32'(hsN - h0), 32'd3);
    waitDone(1'b0, 400, dn, rsp);
    @(posedge clk); #1;
    checkOutput("b2b spacing 1", 32'(hsCyc[h0 + 1] - hsCyc[h0]), 32'd137);
    checkOutput("b2b spacing 2", 32'(hsCyc[h0 + 2] - hsCyc[h0 + 1]), 32'd137);
    checkOutput("b2b ncs gap 1", 32'(gapRuns[g0 + 1]), 32'd5);
    checkOutput("b2b ncs gap 2", 32'(gapRuns[g0 + 2]), 32'd5);
    checkOutput("b2b rising edges", 32'(rises - r0), 32'd48);
    checkOutput("b2b frame bits", {16'd0, shiftCap[15:0]}, 32'h7F3C);
    checkOutput("ready while busy", 32'(rdyViol), 32'd0);

    // Asynchronous reset at the 7th rising sclk edge
    d0 = doneCnt;
    applyStimulus(1'b0, 1'b1, 7'h04, 8'h80, hs);
    k = 0;
    pl = sclk;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (sclk && !pl) k = k + 1;
      pl = sclk;
      if (k == 7) break;
    end
    checkOutput("rises before reset", 32'(k), 32'd7);
    rst = 1'b1;
    #1;
    checkOutput("abort sclk", 32'(sclk), 32'd0);
    checkOutput("abort ncs", 32'(ncs), 32'd1);
    checkOutput("abort copi", 32'(copi), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    checkOutput("no done after abort", 32'(doneCnt - d0), 32'd0);
    checkOutput("ready after abort", 32'(reqReady), 32'd1);
    applyStimulus(1'b0, 1'b1, 7'h02, 8'h0F, hs);
    waitDone(1'b0, 400, dn, rsp);
    @(posedge clk); #1;
    checkOutput("frame after abort", {16'd0, shiftCap[15:0]}, 32'h820F);

    // Minimum timing parameters on the fast instance
    r0 = fRises; v0 = fViol;
    applyStimulus(1'b1, 1'b1, 7'h55, 8'h5A, hs);
    waitDone(1'b1, 200, dn, rsp);
    checkOutput("fast latency", 32'(dn - hs), 32'd67);
    @(negedge clk);
    checkOutput("fast done width", 32'(fDone), 32'd0);
    checkOutput("fast ready", 32'(fReady), 32'd1);
    @(posedge clk); #1;
    checkOutput("fast rising edges", 32'(fRises - r0), 32'd16);
    checkOutput("fast frame bits", {16'd0, fShift[15:0]}, 32'hD55A);
    checkOutput("fast copi stable", 32'(fViol - v0), 32'd0);
`ifdef SPI_CONTROLLER_READBACK_EN
    checkOutput("fast readback", {24'd0, rsp}, 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
